// File: rtl/adder_pkg.sv
// adder_pkg: shared defaults and chunk-width derivation for the pipelined adder
package adder_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_STAGES = 4;
  function automatic int chunk_of(input int width, input int stages);
    return width / stages;
  endfunction
endpackage

// File: rtl/adder_chunk.sv
// adder_chunk: W-bit ripple-carry slice built from full-adder cells
module adder_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  logic c;
  // ripple the carry through one full-adder cell per bit
  always_comb begin
    s = '0;
    c = ci;
    for (int i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: add/subtract split into STAGES carry-registered chunks with valid/ready flow control
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CHUNK = chunk_of(WIDTH, STAGES);
  if (WIDTH % STAGES != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad
    $error("pipelined_adder: WIDTH must be 4..64 and a multiple of STAGES");
  end
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IW = WIDTH - k * CHUNK;
    logic [IW-1:0] ai, bi;
    logic ci, vi, co, adv, adv_nx, v_q, c_q;
    logic [CHUNK-1:0] cs;
    logic [(k+1)*CHUNK-1:0] sn, s_q;
    if (k == 0) begin : g_in
      assign ai = a;
      assign bi = sub ? ~b : b;
      assign ci = cin ^ sub;
      assign vi = in_valid;
      assign sn = cs;
    end else begin : g_mid
      assign ai = g_stage[k-1].g_fwd.a_q;
      assign bi = g_stage[k-1].g_fwd.b_q;
      assign ci = g_stage[k-1].c_q;
      assign vi = g_stage[k-1].v_q;
      assign sn = {cs, g_stage[k-1].s_q};
    end
    if (k == STAGES - 1) begin : g_last
      assign adv_nx = out_ready;
    end else begin : g_chain
      assign adv_nx = g_stage[k+1].adv;
    end
    assign adv = !v_q || adv_nx;
    adder_chunk #(.W(CHUNK)) u_chunk (
      .a (ai[CHUNK-1:0]),
      .b (bi[CHUNK-1:0]),
      .ci(ci),
      .s (cs),
      .co(co)
    );
    // stage valid, carry and completed low sum chunks
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= vi;
        c_q <= co;
        s_q <= sn;
      end
    end
    if (k < STAGES - 1) begin : g_fwd
      logic [IW-CHUNK-1:0] a_q, b_q;
      // operand chunks not yet summed travel with the stage
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= ai[IW-1:CHUNK];
          b_q <= bi[IW-1:CHUNK];
        end
      end
    end else begin : g_sign
      logic sa_q, sb_q;
      // operand sign bits kept for overflow detection at the output
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sa_q <= 1'b0;
          sb_q <= 1'b0;
        end else if (adv) begin
          sa_q <= ai[IW-1];
          sb_q <= bi[IW-1];
        end
      end
    end
  end
  assign in_ready = g_stage[0].adv;
  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum = g_stage[STAGES-1].s_q;
  assign cout = g_stage[STAGES-1].c_q;
  assign ovf = (g_stage[STAGES-1].g_sign.sa_q == g_stage[STAGES-1].g_sign.sb_q) &&
               (sum[WIDTH-1] != g_stage[STAGES-1].g_sign.sa_q);
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed and streamed checks of the pipelined adder
module tb_pipelined_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
  logic out_valid, out_ready = 1'b0, cout, ovf;
  logic [31:0] a = '0, b = '0, sum;
  int n_cmp = 0, n_bad = 0;
  logic [33:0] q[$];
  logic stall_prev = 1'b0;
  logic [33:0] prev_out = '0;
  always #5 clk = ~clk;
  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic c, input logic s);
    logic [31:0] ye;
    logic [32:0] r;
    ye = s ? ~y : y;
    r = {1'b0, x} + {1'b0, ye} + {32'd0, c ^ s};
    return {(x[31] == ye[31]) && (r[31] != x[31]), r};
  endfunction
  task automatic tick();
    logic [33:0] e;
    #1;
    if (stall_prev) begin
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_out", {30'd0, ovf, cout, sum}, {30'd0, prev_out});
    end
    check("in_ready", {63'd0, in_ready}, {63'd0, !(q.size() == 4 && !out_ready)});
    if (out_valid && out_ready) begin
      if (q.size() == 0) check("spurious", {63'd0, out_valid}, 64'd0);
      else begin
        e = q.pop_front();
        check("result", {30'd0, ovf, cout, sum}, {30'd0, e});
      end
    end
    if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
    stall_prev = out_valid && !out_ready;
    prev_out = {ovf, cout, sum};
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic send_one(input logic [31:0] x, input logic [31:0] y, input logic c, input logic s,
                          input logic [31:0] es, input logic ec, input logic eo);
    int lat;
    a = x; b = y; cin = c; sub = s; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'd4);
    check("dir_sum", {32'd0, sum}, {32'd0, es});
    check("dir_flags", {62'd0, cout, ovf}, {62'd0, ec, eo});
    tick();
  endtask
  initial begin
    #1;
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out", {30'd0, ovf, cout, sum}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_ready", {63'd0, in_ready}, 64'd1);
    check("rel_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    send_one(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    send_one(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    send_one(32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    send_one(32'h0000_FFFF, 32'h1, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
    send_one(32'd10, 32'd3, 1'b1, 1'b1, 32'd6, 1'b1, 1'b0);
    send_one(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h1, 1'b1, 1'b1);
    send_one(32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("stream_drain", 64'(q.size()), 64'd0);
    for (int i = 0; i < 150; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom); in_valid = 1'b1;
      out_ready = $urandom_range(0, 9) >= 3;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    check("stall_drain", 64'(q.size()), 64'd0);
    for (int i = 0; i < 2; i++) begin
      a = 32'h1234_0000 + 32'(i); b = 32'h1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_out", {30'd0, ovf, cout, sum}, 64'd0);
    q.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("post_rst_valid", {63'd0, out_valid}, 64'd0);
      tick();
    end
    send_one(32'h0000_FFFF, 32'h1, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
